mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit data-memory words; power of two, 4..1024.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port stall  input  1  hold the MEM/WB register and suppress the store.
REQ-005 Port flush  input  1  kill the instruction currently presented.
REQ-006 Port inValid  input  1  the presented EX/MEM slot holds a real instruction.
REQ-007 Ports inAdder  input  32 (branch target); inZf  input  1 (ALU zero); inOutAlu  input  32 (ALU result / byte address); inRD2  input  32 (store data); inMux5b  input  5 (destination register).
REQ-008 Ports inMemRead, inMemWrite, inMemToReg, inRegWrite, inBranch  input  1 each  control bits from the EX/MEM buffer.
REQ-009 Ports outPcSrc  output  1 and outBranchTarget  output  32  combinational branch redirect to fetch.
REQ-010 Ports outReadData  output  32; outOutAlu  output  32; outMux5b  output  5; outMemToReg  output  1; outRegWrite  output  1; outValid  output  1; outMisalign  output  1  registered MEM/WB fields.
REQ-011 Port outStoreCount  output  16  registered count of committed stores.

Function
REQ-012 Word index = inOutAlu[log2(DEPTH)+1:2]; upper address bits ignored, so addresses wrap modulo DEPTH*4.
REQ-013 Access = inValid & (inMemRead | inMemWrite); misaligned = access & (inOutAlu[1:0] != 0).
REQ-014 Store commits at rising edge only when inValid & inMemWrite & !misaligned & !stall & !flush & !rst; writes inRD2 to the indexed word.
REQ-015 Memory read is asynchronous from the array; a load sees every store committed on an earlier edge (store at edge N, load in the following cycle returns new data).
REQ-016 outPcSrc = inValid & inBranch & inZf & !flush; outBranchTarget = inAdder, unconditionally.
REQ-017 Normal edge (no rst, flush, stall): outReadData <= array word if inMemRead else 0; outOutAlu <= inOutAlu; outMux5b <= inMux5b; outMemToReg <= inMemToReg; outValid <= inValid; outMisalign <= misaligned; outRegWrite <= inValid & inRegWrite & !misaligned.
REQ-018 Latency: one cycle from EX/MEM inputs to MEM/WB outputs.
REQ-019 Priority rst > flush > stall > normal.
REQ-020 Flush edge: outValid, outRegWrite, outMemToReg, outMisalign <= 0; data fields <= 0; no store; outStoreCount unchanged.
REQ-021 Stall edge: all MEM/WB outputs and outStoreCount hold; no store, so a held store commits exactly once after stall drops.
REQ-022 outStoreCount increments by 1 on each committed store; saturates at 0xFFFF, never wraps.
REQ-023 Misaligned access: no store, load data forced to 0, outRegWrite 0, outMisalign 1 for exactly that instruction's MEM/WB cycle.
REQ-024 inMemRead and inMemWrite both high: treated as a store; outReadData 0.

Reset
REQ-025 rst asserted: all registered outputs to 0 immediately, independent of clk; outStoreCount to 0.
REQ-026 Memory array contents are not reset; a store in flight when rst rises is dropped.
REQ-027 First edge after rst falls behaves as a normal edge.

Verification
REQ-028 Store inOutAlu=0x10, inRD2=0xDEADBEEF, then load 0x10 with inRegWrite=1 -> next cycle outReadData=0xDEADBEEF, outRegWrite=1, outStoreCount=1.
REQ-029 DEPTH=64: store 0x5A5A5A5A to 0x100, load 0x000 -> outReadData=0x5A5A5A5A (wrap).
REQ-030 Store to 0x13 (misaligned) then load 0x10 -> outMisalign=1 for store cycle, memory unchanged, outStoreCount unchanged.
REQ-031 Store 0x11111111 to 0x20 held by stall for 3 cycles -> outputs hold, outStoreCount increments exactly once after release.
REQ-032 inBranch=1, inZf=1, inAdder=0x00400040, flush toggled -> outPcSrc=1 with flush=0, 0 with flush=1; flushed slot gives outValid=0, outRegWrite=0.
REQ-033 Store issued with rst rising mid-cycle -> all outputs 0 immediately, store not committed, outStoreCount=0; 65536 stores -> outStoreCount=0xFFFF.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bus for the memory stage: pipeline controls, incoming
// EX/MEM fields, the branch redirect and the registered MEM/WB fields.
interface mem_stage_if;
    logic        stall;
    logic        flush;
    logic        inValid;
    logic [31:0] inAdder;
    logic        inZf;
    logic [31:0] inOutAlu;
    logic [31:0] inRD2;
    logic [4:0]  inMux5b;
    logic        inMemRead;
    logic        inMemWrite;
    logic        inMemToReg;
    logic        inRegWrite;
    logic        inBranch;

    logic        outPcSrc;
    logic [31:0] outBranchTarget;
    logic [31:0] outReadData;
    logic [31:0] outOutAlu;
    logic [4:0]  outMux5b;
    logic        outMemToReg;
    logic        outRegWrite;
    logic        outValid;
    logic        outMisalign;
    logic [15:0] outStoreCount;

    modport master (
        output stall, flush, inValid, inAdder, inZf, inOutAlu, inRD2, inMux5b,
               inMemRead, inMemWrite, inMemToReg, inRegWrite, inBranch,
        input  outPcSrc, outBranchTarget, outReadData, outOutAlu, outMux5b,
               outMemToReg, outRegWrite, outValid, outMisalign, outStoreCount
    );

    modport slave (
        input  stall, flush, inValid, inAdder, inZf, inOutAlu, inRD2, inMux5b,
               inMemRead, inMemWrite, inMemToReg, inRegWrite, inBranch,
        output outPcSrc, outBranchTarget, outReadData, outOutAlu, outMux5b,
               outMemToReg, outRegWrite, outValid, outMisalign, outStoreCount
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word-addressed data memory with async read, branch
// redirect, and the MEM/WB register with flush/stall and a saturating store count.
module mem_stage #(
    parameter int DEPTH = 64
) (
    input logic        clk,
    input logic        rst,
    mem_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wordIdx;
    logic          access;
    logic          misaligned;
    logic          doStore;
    logic          doLoad;
    logic [31:0]   loadData;
    logic          unusedAddrBits;

    // Upper address bits are deliberately dropped so accesses wrap modulo DEPTH words.
    assign wordIdx        = bus.inOutAlu[AW+1:2];
    assign unusedAddrBits = ^bus.inOutAlu[31:AW+2];

    assign access     = bus.inValid & (bus.inMemRead | bus.inMemWrite);
    assign misaligned = access & (bus.inOutAlu[1:0] != 2'b00);
    assign doStore    = bus.inValid & bus.inMemWrite & ~misaligned &
                        ~bus.stall & ~bus.flush & ~rst;
    // A read+write instruction behaves as a store, so it returns no load data.
    assign doLoad     = bus.inMemRead & ~bus.inMemWrite & ~misaligned;
    assign loadData   = doLoad ? mem[wordIdx] : 32'h0;

    assign bus.outPcSrc        = bus.inValid & bus.inBranch & bus.inZf & ~bus.flush;
    assign bus.outBranchTarget = bus.inAdder;

    always_ff @(posedge clk) begin
        if (doStore) mem[wordIdx] <= bus.inRD2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.outReadData   <= '0;
            bus.outOutAlu     <= '0;
            bus.outMux5b      <= '0;
            bus.outMemToReg   <= 1'b0;
            bus.outRegWrite   <= 1'b0;
            bus.outValid      <= 1'b0;
            bus.outMisalign   <= 1'b0;
            bus.outStoreCount <= '0;
        end else if (bus.flush) begin
            bus.outReadData   <= '0;
            bus.outOutAlu     <= '0;
            bus.outMux5b      <= '0;
            bus.outMemToReg   <= 1'b0;
            bus.outRegWrite   <= 1'b0;
            bus.outValid      <= 1'b0;
            bus.outMisalign   <= 1'b0;
        end else if (!bus.stall) begin
            bus.outReadData <= loadData;
            bus.outOutAlu   <= bus.inOutAlu;
            bus.outMux5b    <= bus.inMux5b;
            bus.outMemToReg <= bus.inMemToReg;
            bus.outRegWrite <= bus.inValid & bus.inRegWrite & ~misaligned;
            bus.outValid    <= bus.inValid;
            bus.outMisalign <= misaligned;
            if (doStore && bus.outStoreCount != 16'hFFFF)
                bus.outStoreCount <= bus.outStoreCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes hand-computed MEM/WB
// expectations, a monitor pops one per clock edge and compares.
module tb_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_if bus ();
    mem_stage #(.DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       name;
        logic [31:0] readData;
        logic [31:0] outAlu;
        logic [4:0]  mux5b;
        logic        memToReg;
        logic        regWrite;
        logic        valid;
        logic        misalign;
        logic [15:0] storeCount;
    } exp_t;

    exp_t sbq[$];
    int   nCmp = 0;
    int   nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [31:0] rdata, input logic [31:0] alu,
                                input logic [4:0] mux, input logic m2r, input logic rw,
                                input logic v, input logic mis, input logic [15:0] cnt);
        exp_t e;
        e.name = name; e.readData = rdata; e.outAlu = alu; e.mux5b = mux; e.memToReg = m2r;
        e.regWrite = rw; e.valid = v; e.misalign = mis; e.storeCount = cnt;
        return e;
    endfunction

    // Monitor: one MEM/WB result is visible just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.name, ".readData"}, bus.outReadData, e.readData);
            chk({e.name, ".outAlu"}, bus.outOutAlu, e.outAlu);
            chk({e.name, ".mux5b"}, {27'b0, bus.outMux5b}, {27'b0, e.mux5b});
            chk({e.name, ".memToReg"}, {31'b0, bus.outMemToReg}, {31'b0, e.memToReg});
            chk({e.name, ".regWrite"}, {31'b0, bus.outRegWrite}, {31'b0, e.regWrite});
            chk({e.name, ".valid"}, {31'b0, bus.outValid}, {31'b0, e.valid});
            chk({e.name, ".misalign"}, {31'b0, bus.outMisalign}, {31'b0, e.misalign});
            chk({e.name, ".storeCount"}, {16'b0, bus.outStoreCount}, {16'b0, e.storeCount});
        end
    end

    task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [31:0] alu, input logic [31:0] rd2,
                         input logic [4:0] mux);
        bus.inValid = v; bus.inMemRead = rd; bus.inMemWrite = wr; bus.inMemToReg = m2r;
        bus.inRegWrite = rw; bus.inOutAlu = alu; bus.inRD2 = rd2; bus.inMux5b = mux;
    endtask

    // Push the expectation for the current slot, then advance one cycle.
    task automatic issue(input exp_t e);
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAllZero(input string name);
        chk({name, ".readData"}, bus.outReadData, 32'h0);
        chk({name, ".outAlu"}, bus.outOutAlu, 32'h0);
        chk({name, ".flags"}, {27'b0, bus.outMemToReg, bus.outRegWrite, bus.outValid,
                               bus.outMisalign, 1'b0}, 32'h0);
        chk({name, ".mux5b"}, {27'b0, bus.outMux5b}, 32'h0);
        chk({name, ".storeCount"}, {16'b0, bus.outStoreCount}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        bus.stall = 0; bus.flush = 0; bus.inAdder = 0; bus.inZf = 0; bus.inBranch = 0;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // store then load back
        drive(1, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(mk("st10", 32'h0, 32'h10, 5'd0, 0, 0, 1, 0, 16'd1));
        drive(1, 1, 0, 1, 1, 32'h10, 32'h0, 5'd5);
        issue(mk("ld10", 32'hDEADBEEF, 32'h10, 5'd5, 1, 1, 1, 0, 16'd1));

        // address wrap: 0x100 aliases word 0 with 64 words
        drive(1, 0, 1, 0, 0, 32'h100, 32'h5A5A5A5A, 5'd0);
        issue(mk("st100", 32'h0, 32'h100, 5'd0, 0, 0, 1, 0, 16'd2));
        drive(1, 1, 0, 1, 1, 32'h0, 32'h0, 5'd7);
        issue(mk("ld000", 32'h5A5A5A5A, 32'h0, 5'd7, 1, 1, 1, 0, 16'd2));

        // misaligned store is dropped; memory at 0x10 untouched
        drive(1, 0, 1, 0, 1, 32'h13, 32'h12345678, 5'd3);
        issue(mk("stMis", 32'h0, 32'h13, 5'd3, 0, 0, 1, 1, 16'd2));
        drive(1, 1, 0, 1, 1, 32'h10, 32'h0, 5'd4);
        issue(mk("ld10b", 32'hDEADBEEF, 32'h10, 5'd4, 1, 1, 1, 0, 16'd2));
        drive(1, 1, 0, 1, 1, 32'h12, 32'h0, 5'd9);
        issue(mk("ldMis", 32'h0, 32'h12, 5'd9, 1, 0, 1, 1, 16'd2));

        // store held by stall for three cycles: outputs hold, single commit on release
        bus.stall = 1;
        drive(1, 0, 1, 0, 0, 32'h20, 32'h11111111, 5'd1);
        for (int i = 0; i < 3; i++)
            issue(mk("stall", 32'h0, 32'h12, 5'd9, 1, 0, 1, 1, 16'd2));
        bus.stall = 0;
        issue(mk("stRel", 32'h0, 32'h20, 5'd1, 0, 0, 1, 0, 16'd3));
        drive(1, 1, 0, 1, 1, 32'h20, 32'h0, 5'd2);
        issue(mk("ld20", 32'h11111111, 32'h20, 5'd2, 1, 1, 1, 0, 16'd3));

        // read+write together behaves as a store with no load data
        drive(1, 1, 1, 1, 1, 32'h30, 32'h77777777, 5'd6);
        issue(mk("rdwr", 32'h0, 32'h30, 5'd6, 1, 1, 1, 0, 16'd4));

        // branch redirect, then the same slot flushed (carrying a store that must die)
        bus.inBranch = 1; bus.inZf = 1; bus.inAdder = 32'h00400040;
        drive(1, 0, 0, 0, 1, 32'h44, 32'h0, 5'd8);
        #1;
        chk("pcSrc.noFlush", {31'b0, bus.outPcSrc}, 32'h1);
        chk("branchTarget", bus.outBranchTarget, 32'h00400040);
        issue(mk("br", 32'h0, 32'h44, 5'd8, 0, 1, 1, 0, 16'd4));
        bus.flush = 1;
        drive(1, 0, 1, 1, 1, 32'h30, 32'h99999999, 5'd8);
        #1;
        chk("pcSrc.flush", {31'b0, bus.outPcSrc}, 32'h0);
        issue(mk("flushed", 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 16'd4));
        bus.flush = 0; bus.inBranch = 0; bus.inZf = 0;
        drive(1, 1, 0, 1, 1, 32'h30, 32'h0, 5'd6);
        issue(mk("ld30", 32'h77777777, 32'h30, 5'd6, 1, 1, 1, 0, 16'd4));

        // bubble with store bits set commits nothing; branch with Zf=0 does not redirect
        bus.inBranch = 1;
        drive(0, 0, 1, 0, 1, 32'h30, 32'h55555555, 5'd6);
        #1;
        chk("pcSrc.zf0", {31'b0, bus.outPcSrc}, 32'h0);
        issue(mk("bubble", 32'h0, 32'h30, 5'd6, 0, 0, 0, 0, 16'd4));
        bus.inBranch = 0;
        drive(1, 1, 0, 0, 0, 32'h30, 32'h0, 5'd0);
        issue(mk("ld30b", 32'h77777777, 32'h30, 5'd0, 0, 0, 1, 0, 16'd4));

        // reset rising mid-cycle with a store presented: immediate clear, store dropped
        drive(1, 0, 1, 0, 0, 32'h20, 32'hBADBAD00, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("asyncRst");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 1, 1, 32'h20, 32'h0, 5'd2);
        issue(mk("ldPostRst", 32'h11111111, 32'h20, 5'd2, 1, 1, 1, 0, 16'd0));

        // counter saturation
        drive(1, 0, 1, 0, 0, 32'h0, 32'h0, 5'd0);
        repeat (65534) @(negedge clk);
        issue(mk("cnt65536", 32'h0, 32'h0, 5'd0, 0, 0, 1, 0, 16'hFFFF));
        issue(mk("cntSat", 32'h0, 32'h0, 5'd0, 0, 0, 1, 0, 16'hFFFF));

        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        chk("scoreboardDrained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
